uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with error detection and an integrated receive FIFO. It is the next-generation replacement for the fixed 8N1 receiver-plus-single-byte-buffer pair. It samples the asynchronous RX line on the shared oversampling tick and supports configurable data width, parity and stop bits. Each received word is stored with its parity/framing status in a first-word-fall-through FIFO that the host logic drains.

## Interface
- DBIT, 8: data bits per frame, 5..9, LSB first on the line.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: tick_clk pulses per bit time, even, ≥8.
- FIFO_AW, 2: FIFO depth = 2**FIFO_AW entries.
- Clocking and reset: one clock; reset is synchronous and active-high.
- MCLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- tick_clk  in  1  oversampling strobe, one MCLK cycle wide.
- RX  in  1  asynchronous serial line, idle high.
- rd_en  in  1  pop FIFO head; ignored when empty.
- clr_ovr  in  1  clears sticky overrun.
- DATAOUT  out  DBIT  FIFO head data.
- parity_err  out  1  head entry parity error; 0 when PARITY=0.
- frame_err  out  1  head entry framing error.
- rx_valid  out  1  FIFO not empty; head fields valid.
- overrun  out  1  sticky: a word was dropped because the FIFO was full.
- fifo_count  out  FIFO_AW+1  entries held.

## Operation
- Synchroniser: two flops on RX, reset to 1. The FSM uses only the synchronised value rxs.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_IDLE. The tick counter and bit counter advance only on tick_clk.
- IDLE: rxs=0 → START, tick counter=0.
- START: at tick count OVERSAMPLE/2-1, if rxs=0 → DATA with counters=0, else → IDLE (glitch rejected, nothing stored).
- DATA: every OVERSAMPLE ticks, sample rxs and shift it in at the MSB of a DBIT-wide shift register (right shift, LSB-first result). After DBIT samples → PAR if PARITY≠0, else STOP.
- PAR: sample after OVERSAMPLE ticks. Even mode: error if XOR(data, parity bit)=1. Odd mode: error if XOR(data, parity bit)=0.
- STOP: sample after OVERSAMPLE ticks, repeated STOP_BITS times. Any stop sample 0 sets frame error.
- Commit: on the tick of the last stop sample, write {frame_err, parity_err, data} to the FIFO. The FSM then goes to IDLE if the sample was 1, or to WAIT_IDLE if 0.
- WAIT_IDLE: remain until rxs=1, then → IDLE. A held-low break therefore yields exactly one entry (data 0, frame_err=1).
- FIFO: write with full and no simultaneous pop → word dropped, overrun set. Write and pop in the same cycle with the FIFO full → both occur, no overrun. Pop with the FIFO empty → ignored. Pointers wrap modulo depth.
- overrun: cleared by clr_ovr or RST. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values: DATAOUT=0, parity_err=0, frame_err=0, rx_valid=0, overrun=0, fifo_count=0. FSM=IDLE, synchroniser=1.
- RST mid-frame discards the partial frame and empties the FIFO in the same edge.
- RX-to-rxs latency: 2 MCLK cycles.
- Commit-to-visibility: FIFO written at the commit edge. rx_valid, fifo_count and head fields update at that edge, so they are visible the next cycle.
- rd_en pop: the next entry (or rx_valid=0) is visible the cycle after the rd_en edge.
- Back-to-back frames: a start edge is accepted from the first cycle after the final stop sample, i.e. half a bit before the nominal end of the stop bit.
- Sampling: each bit is sampled OVERSAMPLE ticks after the previous one, ±1 tick of line skew tolerance, nominally mid-bit.
- The tick counter width is $clog2(OVERSAMPLE). The bit counter width is $clog2(DBIT+1).

## Test plan
- Defaults, frame 0xA5, one tick every 4 MCLK → one entry: DATAOUT=0xA5, rx_valid=1, fifo_count=1, errors 0. rd_en → rx_valid=0 next cycle.
- DBIT=7, PARITY=1, frame 0x41 with parity bit 1 (wrong) → DATAOUT=0x41, parity_err=1. Same frame with parity bit 0 → parity_err=0.
- RX held low for 3 frame times then high → exactly one entry: 0x00, frame_err=1. No further entries until a valid frame 0x3C, which is stored error-free.
- FIFO_AW=2: send 5 frames 0x01..0x05 without reads → fifo_count=4, overrun=1, reads return 0x01..0x04. clr_ovr → overrun=0.
- 4-tick low glitch on idle RX → FSM returns to IDLE, no entry. A following frame 0x5A is received correctly.
- STOP_BITS=2, second stop bit driven 0 → frame_err=1. Separately, RST asserted mid-DATA → all outputs at reset values next cycle, and the next frame 0xC3 is received cleanly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable data width, parity and stop bits) feeding a
// first-word-fall-through FIFO of {frame_err, parity_err, data} entries.
module uart_rx_fifo #(
    parameter int DBIT       = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 2
) (
    input  logic              MCLK,
    input  logic              RST,
    input  logic              tick_clk,
    input  logic              RX,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DBIT-1:0]   DATAOUT,
    output logic              parity_err,
    output logic              frame_err,
    output logic              rx_valid,
    output logic              overrun,
    output logic [FIFO_AW:0]  fifo_count,
    output logic [2:0]        o_dbg_state
);
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DBIT + 1);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int EW    = DBIT + 2;

    localparam logic [TW-1:0]    TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(DBIT - 1);
    localparam logic [BW-1:0]    STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PAR       = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic            r_sync1;
    logic            r_sync2;
    logic [2:0]      r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [BW-1:0]   r_bit_cnt;
    logic [DBIT-1:0] r_shift;
    logic            r_perr;
    logic            r_ferr;

    logic            w_rxs;
    logic            w_tick_done;
    logic            w_par_xor;
    logic            w_commit;
    logic [EW-1:0]   w_wr_word;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs       = r_sync2;
    assign w_tick_done = tick_clk && (r_tick_cnt == TICK_LAST);
    assign w_par_xor   = ^{r_shift, w_rxs};
    assign w_commit    = (r_state == S_STOP) && w_tick_done && (r_bit_cnt == STOP_LAST);
    assign w_wr_word   = {r_ferr | ~w_rxs, r_perr, r_shift};

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (tick_clk) begin
                        if (r_tick_cnt == TICK_HALF) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                            r_state    <= w_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick_done) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rxs, r_shift[DBIT-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (tick_clk) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (w_tick_done) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_perr     <= (PARITY == 1) ? w_par_xor : ~w_par_xor;
                        r_state    <= S_STOP;
                    end else if (tick_clk) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick_done) begin
                        r_tick_cnt <= '0;
                        if (!w_rxs) begin
                            r_ferr <= 1'b1;
                        end
                        // Last stop sample commits; a low line here means a break in progress.
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= w_rxs ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (tick_clk) begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    logic [EW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overrun;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [EW-1:0]      w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL);
    assign w_pop   = rd_en && !w_empty;
    // A pop in the same cycle frees the slot the full FIFO would otherwise refuse.
    assign w_push  = w_commit && (!w_full || w_pop);
    assign w_drop  = w_commit && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge MCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Head fields are forced to zero while empty so reset and drained states read clean.
    assign DATAOUT     = w_empty ? '0 : w_head[DBIT-1:0];
    assign parity_err  = w_empty ? 1'b0 : w_head[DBIT];
    assign frame_err   = w_empty ? 1'b0 : w_head[DBIT+1];
    assign rx_valid    = !w_empty;
    assign overrun     = r_overrun;
    assign fifo_count  = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one 8N1 instance and one 7E2 instance, driven with
// serial frames; expected entries are queued as frames are sent.
module tb_uart_rx_fifo;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CYC  = OS * TICK_DIV;

    logic       MCLK = 1'b0;
    logic       RST;
    logic       tick;
    logic       rx_a, rx_b, rd_a, rd_b, clr_a, clr_b;

    logic [7:0] dout_a;
    logic       pe_a, fe_a, val_a, ovr_a;
    logic [2:0] cnt_a;
    logic [2:0] st_a;
    logic [6:0] dout_b;
    logic       pe_b, fe_b, val_b, ovr_b;
    logic [2:0] cnt_b;
    logic [2:0] st_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];
    logic [10:0] exp_w;

    uart_rx_fifo u_a (
        .MCLK(MCLK), .RST(RST), .tick_clk(tick), .RX(rx_a), .rd_en(rd_a), .clr_ovr(clr_a),
        .DATAOUT(dout_a), .parity_err(pe_a), .frame_err(fe_a), .rx_valid(val_a),
        .overrun(ovr_a), .fifo_count(cnt_a), .o_dbg_state(st_a)
    );

    uart_rx_fifo #(.DBIT(7), .PARITY(1), .STOP_BITS(2)) u_b (
        .MCLK(MCLK), .RST(RST), .tick_clk(tick), .RX(rx_b), .rd_en(rd_b), .clr_ovr(clr_b),
        .DATAOUT(dout_b), .parity_err(pe_b), .frame_err(fe_b), .rx_valid(val_b),
        .overrun(ovr_b), .fifo_count(cnt_b), .o_dbg_state(st_b)
    );

    initial forever #5 MCLK = ~MCLK;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge MCLK);
            tick = 1'b1;
            @(negedge MCLK);
            tick = 1'b0;
        end
    end

    task automatic send_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (BIT_CYC) @(negedge MCLK);
    endtask

    // Sends one frame; when keep is set the expected entry is queued (even parity model).
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input bit use_par, input logic pbit, input logic s1,
                              input logic s2, input int nstop, input bit keep);
        logic [8:0] dm;
        logic       p;
        logic       fe;
        dm = '0;
        p  = pbit;
        for (int i = 0; i < nbits; i++) begin
            dm[i] = data[i];
            p     = p ^ data[i];
        end
        fe = ~s1 | ((nstop == 2) & ~s2);
        if (keep) begin
            if (sel) exp_b.push_back({fe, use_par & p, dm});
            else     exp_a.push_back({fe, use_par & p, dm});
        end
        send_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(sel, data[i]);
        if (use_par) send_bit(sel, pbit);
        send_bit(sel, s1);
        if (nstop == 2) send_bit(sel, s2);
        if (sel) rx_b = 1'b1;
        else     rx_a = 1'b1;
        repeat (BIT_CYC / 4) @(negedge MCLK);
    endtask

    task automatic test_reset;
        RST = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        repeat (4) @(negedge MCLK);
        RST = 1'b0;
        @(negedge MCLK);
        n_checks++;
        if ({dout_a, pe_a, fe_a, val_a, ovr_a, cnt_a, st_a} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", {dout_a, pe_a, fe_a, val_a, ovr_a, cnt_a, st_a});
        end
        n_checks++;
        if ({dout_b, pe_b, fe_b, val_b, ovr_b, cnt_b, st_b} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", {dout_b, pe_b, fe_b, val_b, ovr_b, cnt_b, st_b});
        end
    endtask

    task automatic test_basic;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1);
        n_checks++;
        if (cnt_a !== 3'd1) begin
            n_fail++; $display("FAIL basic_count: got %0d expected 1", cnt_a);
        end
        while (exp_a.size() > 0) begin
            exp_w = exp_a.pop_front();
            n_checks++;
            if ({val_a, fe_a, pe_a, 1'b0, dout_a} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL basic_head: got %h expected %h", {val_a, fe_a, pe_a, 1'b0, dout_a}, {1'b1, exp_w});
            end
            rd_a = 1'b1; @(negedge MCLK); rd_a = 1'b0;
        end
        n_checks++;
        if ({val_a, cnt_a} !== 4'h0) begin
            n_fail++; $display("FAIL basic_pop: got valid=%b count=%0d expected 0/0", val_a, cnt_a);
        end
    endtask

    task automatic test_parity_stop;
        send_frame(1, 9'h041, 7, 1, 1'b1, 1'b1, 1'b1, 2, 1);
        send_frame(1, 9'h041, 7, 1, 1'b0, 1'b1, 1'b1, 2, 1);
        send_frame(1, 9'h02A, 7, 1, 1'b1, 1'b1, 1'b0, 2, 1);
        send_frame(1, 9'h015, 7, 1, 1'b1, 1'b0, 1'b1, 2, 1);
        send_frame(1, 9'h07F, 7, 1, 1'b1, 1'b1, 1'b1, 2, 1);
        n_checks++;
        if ({ovr_b, cnt_b} !== 4'b1100) begin
            n_fail++; $display("FAIL parity_count: got ovr=%b count=%0d expected 1/4", ovr_b, cnt_b);
        end
        while (exp_b.size() > 1) begin
            exp_w = exp_b.pop_front();
            n_checks++;
            if ({val_b, fe_b, pe_b, 2'b00, dout_b} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL parity_head: got %h expected %h", {val_b, fe_b, pe_b, 2'b00, dout_b}, {1'b1, exp_w});
            end
            rd_b = 1'b1; @(negedge MCLK); rd_b = 1'b0;
        end
        exp_b.delete();
        clr_b = 1'b1; @(negedge MCLK); clr_b = 1'b0;
        n_checks++;
        if ({val_b, ovr_b} !== 2'b00) begin
            n_fail++; $display("FAIL parity_drain: got valid=%b ovr=%b expected 0/0", val_b, ovr_b);
        end
    endtask

    task automatic test_break;
        rx_a = 1'b0;
        repeat (3 * 10 * BIT_CYC) @(negedge MCLK);
        rx_a = 1'b1;
        repeat (2 * BIT_CYC) @(negedge MCLK);
        exp_a.push_back({1'b1, 1'b0, 9'h000});
        n_checks++;
        if (cnt_a !== 3'd1) begin
            n_fail++; $display("FAIL break_count: got %0d expected 1", cnt_a);
        end
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1);
        while (exp_a.size() > 0) begin
            exp_w = exp_a.pop_front();
            n_checks++;
            if ({val_a, fe_a, pe_a, 1'b0, dout_a} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL break_head: got %h expected %h", {val_a, fe_a, pe_a, 1'b0, dout_a}, {1'b1, exp_w});
            end
            rd_a = 1'b1; @(negedge MCLK); rd_a = 1'b0;
        end
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 9'(i), 8, 0, 1'b0, 1'b1, 1'b1, 1, i <= 4);
        end
        n_checks++;
        if ({ovr_a, cnt_a} !== 4'b1100) begin
            n_fail++; $display("FAIL ovr_full: got ovr=%b count=%0d expected 1/4", ovr_a, cnt_a);
        end
        while (exp_a.size() > 0) begin
            exp_w = exp_a.pop_front();
            n_checks++;
            if ({val_a, fe_a, pe_a, 1'b0, dout_a} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL ovr_head: got %h expected %h", {val_a, fe_a, pe_a, 1'b0, dout_a}, {1'b1, exp_w});
            end
            rd_a = 1'b1; @(negedge MCLK); rd_a = 1'b0;
        end
        n_checks++;
        if (ovr_a !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: got %b expected 1", ovr_a);
        end
        clr_a = 1'b1; rd_a = 1'b1; @(negedge MCLK); clr_a = 1'b0; rd_a = 1'b0;
        n_checks++;
        if ({ovr_a, val_a, cnt_a} !== 5'h00) begin
            n_fail++; $display("FAIL ovr_clear: got ovr=%b valid=%b count=%0d expected 0/0/0", ovr_a, val_a, cnt_a);
        end
    endtask

    task automatic test_glitch;
        rx_a = 1'b0;
        repeat (8) @(negedge MCLK);
        n_checks++;
        if (st_a !== 3'd1) begin
            n_fail++; $display("FAIL glitch_start: got state %0d expected 1", st_a);
        end
        repeat (8) @(negedge MCLK);
        rx_a = 1'b1;
        repeat (BIT_CYC) @(negedge MCLK);
        n_checks++;
        if ({st_a, val_a, cnt_a} !== 7'h00) begin
            n_fail++; $display("FAIL glitch_idle: got state=%0d valid=%b count=%0d expected 0/0/0", st_a, val_a, cnt_a);
        end
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1);
        while (exp_a.size() > 0) begin
            exp_w = exp_a.pop_front();
            n_checks++;
            if ({val_a, fe_a, pe_a, 1'b0, dout_a} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL glitch_head: got %h expected %h", {val_a, fe_a, pe_a, 1'b0, dout_a}, {1'b1, exp_w});
            end
            rd_a = 1'b1; @(negedge MCLK); rd_a = 1'b0;
        end
    endtask

    task automatic test_rst_mid;
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1);
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, junk[i]);
        RST = 1'b1; rx_a = 1'b1;
        @(negedge MCLK);
        exp_a.delete();
        n_checks++;
        if ({dout_a, pe_a, fe_a, val_a, ovr_a, cnt_a, st_a} !== 18'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got %h expected 0", {dout_a, pe_a, fe_a, val_a, ovr_a, cnt_a, st_a});
        end
        RST = 1'b0;
        repeat (BIT_CYC) @(negedge MCLK);
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1);
        n_checks++;
        if (cnt_a !== 3'd1) begin
            n_fail++; $display("FAIL rst_after_count: got %0d expected 1", cnt_a);
        end
        while (exp_a.size() > 0) begin
            exp_w = exp_a.pop_front();
            n_checks++;
            if ({val_a, fe_a, pe_a, 1'b0, dout_a} !== {1'b1, exp_w}) begin
                n_fail++;
                $display("FAIL rst_after_head: got %h expected %h", {val_a, fe_a, pe_a, 1'b0, dout_a}, {1'b1, exp_w});
            end
            rd_a = 1'b1; @(negedge MCLK); rd_a = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_stop();
        test_break();
        test_overrun();
        test_glitch();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
